// File: rtl/icache.sv
// icache: direct-mapped, one-word-per-line instruction cache between pc_reg and mem_ctrl.
module icache #(
  parameter int INDEX_W = 6,
  parameter int ADDR_W  = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        ife_i,
  input  logic [31:0] pc_i,
  input  logic        flush_i,
  output logic        ifready_o,
  output logic [31:0] ifdata_o,
  output logic        miss_req_o,
  output logic [31:0] miss_addr_o,
  input  logic        miss_ready_i,
  input  logic [31:0] miss_data_i
);
  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W - 2;

  typedef enum logic {IDLE, MISS} state_t;

  state_t                     state;
  logic                       drop;
  logic [LINES-1:0]           valid;
  logic [TAG_W-1:0]           tag_arr  [LINES];
  logic [31:0]                data_arr [LINES];
  logic [INDEX_W-1:0]         idx, midx;
  logic [TAG_W-1:0]           tag_in, mtag;
  logic                       hit, accept, fill;

  assign idx    = pc_i[INDEX_W+1:2];
  assign tag_in = pc_i[ADDR_W-1:INDEX_W+2];
  assign midx   = miss_addr_o[INDEX_W+1:2];
  assign mtag   = miss_addr_o[ADDR_W-1:INDEX_W+2];
  assign hit    = valid[idx] && tag_arr[idx] == tag_in;
  assign accept = state == IDLE && ife_i && !ifready_o && !flush_i;
  assign fill   = state == MISS && miss_ready_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      drop        <= 1'b0;
      valid       <= '0;
      ifready_o   <= 1'b0;
      ifdata_o    <= '0;
      miss_req_o  <= 1'b0;
      miss_addr_o <= '0;
    end else if (rdy) begin
      ifready_o <= 1'b0;
      if (accept && hit) begin
        ifready_o <= 1'b1;
        ifdata_o  <= data_arr[idx];
      end else if (accept) begin
        miss_req_o  <= 1'b1;
        miss_addr_o <= pc_i & ~32'd3;
        drop        <= 1'b0;
        state       <= MISS;
      end
      if (state == MISS && flush_i) drop <= 1'b1;
      // A flushed miss still fills the line; only the response is suppressed.
      if (fill) begin
        valid[midx] <= 1'b1;
        miss_req_o  <= 1'b0;
        state       <= IDLE;
        if (!drop && !flush_i) begin
          ifready_o <= 1'b1;
          ifdata_o  <= miss_data_i;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && rdy && fill) begin
      tag_arr[midx]  <= mtag;
      data_arr[midx] <= miss_data_i;
    end
  end
endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped instruction cache placed between pc_reg (fetch requester) and mem_ctrl (byte-serial RAM port).
- On a hit it returns the 32-bit instruction word with 1-cycle latency.
- On a miss it issues one word fetch to mem_ctrl, fills the line, then answers pc_reg.
- Gives the front-end single-cycle fetch for loop bodies instead of the multi-cycle byte-serial RAM path.

Parameters:
- INDEX_W, 6, log2 of the number of lines (64 lines, one 32-bit word per line).
- ADDR_W, 18, significant address bits (RAM and I/O space is 0x0–0x3FFFF).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- rdy  in  1  global ready; 0 freezes all state and outputs
- ife_i  in  1  fetch request from pc_reg
- pc_i  in  32  fetch address; bits [1:0] ignored
- flush_i  in  1  jump/redirect: cancel the in-flight fetch
- ifready_o  out  1  one-cycle pulse: ifdata_o valid for the request
- ifdata_o  out  32  instruction word
- miss_req_o  out  1  word-fetch request to mem_ctrl
- miss_addr_o  out  32  word-aligned miss address
- miss_ready_i  in  1  one-cycle pulse from mem_ctrl: miss_data_i valid
- miss_data_i  in  32  fetched word, little-endian assembled by mem_ctrl

Behaviour:
- Address split:
  - index = pc_i[INDEX_W+1:2]
  - tag = pc_i[ADDR_W-1:INDEX_W+2] (10 bits at defaults)
  - bits above ADDR_W are ignored.
- Storage: valid[2^INDEX_W], tag array, data array, all registers. Lookup is combinational from array outputs; all ports are registered.
- Reset (rst=0, async): all valid bits cleared, state=IDLE, drop=0, ifready_o=0, ifdata_o=0, miss_req_o=0, miss_addr_o=0. Tag and data arrays are not cleared.
- rdy=0: no state, array, or output register changes. Outputs hold their last values.
- States: IDLE, MISS.
- IDLE: a request is accepted when ife_i=1, ifready_o=0, flush_i=0.
  - Hit (valid[index] and tag match): next cycle ifready_o=1, ifdata_o=data[index]; stay IDLE.
  - Miss: next cycle miss_req_o=1, miss_addr_o={pc_i[31:2],2'b00}, drop=0; go to MISS.
- Request cadence: ifready_o is a 1-cycle pulse. The ifready_o=0 qualifier blocks re-accepting the same request in the response cycle, so back-to-back hits complete every 2 cycles.
- MISS: miss_req_o and miss_addr_o are held constant until miss_ready_i=1. On that cycle:
  - Write valid=1, tag, and data at the line of miss_addr_o.
  - Next cycle: miss_req_o=0, state=IDLE.
  - ifready_o=1 and ifdata_o=miss_data_i, unless drop=1 (then ifready_o=0).
- flush_i:
  - In IDLE: suppresses acceptance that cycle; any response pulse due next cycle still occurs only if the request was accepted before the flush cycle.
  - In MISS: sets drop=1. The RAM transaction is never abandoned (mem_ctrl cannot abort mid-word); the line is still filled but no ifready_o is produced.
  - flush_i and miss_ready_i in the same MISS cycle: fill occurs, ifready_o suppressed.
- Miss fill and a same-index request: no new request is accepted until the cycle after the return to IDLE. Lookup therefore sees the filled line.
- ifdata_o holds its last value between pulses.
- Reset mid-MISS: state returns to IDLE, miss_req_o drops immediately, no fill occurs.

Test Plan:
- Reset, then ife_i=1, pc_i=0x00000100 → miss_req_o=1 with miss_addr_o=0x100 one cycle later. Drive miss_ready_i with 0x00500093 → ifready_o=1, ifdata_o=0x00500093 on the next cycle; miss_req_o=0.
- Re-request 0x100 → ifready_o=1 exactly 1 cycle after acceptance, data 0x00500093, no miss_req_o.
- Conflict miss on 0x100+(4<<INDEX_W)=0x200 → miss issued. After fill, 0x100 misses again; verify line replacement.
- flush_i pulsed 2 cycles into a miss on 0x300, with miss_ready_i 5 cycles later → no ifready_o. Then request 0x300 → hit returns the filled word.
- rdy=0 for 3 cycles while MISS with miss_ready_i=0 → miss_req_o and miss_addr_o unchanged, no state change. Then rdy=1 and the fill completes normally.
- Async rst asserted mid-miss (between clock edges) → miss_req_o=0 immediately. A subsequent request to the previously cached 0x100 misses (valid cleared).
